// File: rtl/aludec_pkg.sv
// Shared encodings for the ALU decoder and its iterative multiply/divide unit.
// No logic; constants and types only.
// Imported by aludec_seq and muldiv_iter.
package aludec_pkg;

    // Main-decoder ALU operation classes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    // R-type function fields
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    // ALU control codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_MULTU = 1'b0,
        OP_DIVU  = 1'b1
    } mdop_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned MULTU (shift-add) / DIVU (restoring) datapath, one step per cycle.
// Latency: WIDTH steps after i_start; o_last flags the final step.
// No backpressure: the controller decides when to step or abort.
module muldiv_iter
    import aludec_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  mdop_t            i_op,
    input  logic             i_step,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_srca,
    input  logic [WIDTH-1:0] i_srcb,
    output logic             o_last,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // r_hi/r_lo form the accumulator pair: product for MULTU,
    // remainder/quotient (dividend shifting out of r_lo) for DIVU.
    mdop_t            r_op;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_nxt_hi;
    logic [WIDTH-1:0] w_nxt_lo;

    // One step of either algorithm, selected by the latched op
    always_comb begin
        w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
        w_ge      = (w_rem_sh >= {1'b0, r_opnd});
        // When w_ge holds the true difference is below the divisor, so WIDTH bits suffice
        w_diff    = w_rem_sh[WIDTH-1:0] - r_opnd;
        if (r_op == OP_MULTU) begin
            w_nxt_hi = w_mul_sum[WIDTH:1];
            w_nxt_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end else begin
            w_nxt_hi = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
            w_nxt_lo = {r_lo[WIDTH-2:0], w_ge};
        end
    end

    // Operand/accumulator load, step and counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op   <= OP_MULTU;
            r_opnd <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_cnt  <= '0;
        end else if (i_abort) begin
            r_cnt  <= '0;
        end else if (i_start) begin
            r_op   <= i_op;
            r_opnd <= (i_op == OP_MULTU) ? i_srca : i_srcb;
            r_lo   <= (i_op == OP_MULTU) ? i_srcb : i_srca;
            r_hi   <= '0;
            r_cnt  <= '0;
        end else if (i_step) begin
            r_hi   <= w_nxt_hi;
            r_lo   <= w_nxt_lo;
            r_cnt  <= (r_cnt == LAST_CNT) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign o_last = (r_cnt == LAST_CNT);
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: rtl/aludec_seq.sv
// ALU decoder with sequencing of an iterative MULTU/DIVU unit and HI/LO registers.
// Latency: alucontrol/illegal/stall/hilo_rd combinational; MULTU/DIVU done WIDTH+1 cycles after start.
// Backpressure: stall holds MULTU/DIVU/MFHI/MFLO while the unit is busy; flush aborts.
module aludec_seq
    import aludec_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid,
    input  logic             flush,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [2:0]       alucontrol,
    output logic             illegal,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hilo_rd
);

    state_t           r_state;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic       w_rtype;
    logic       w_is_md;
    logic       w_is_mf;
    logic [2:0] w_rt_ctrl;
    logic       w_rt_known;
    logic       w_start;
    logic       w_step;
    logic       w_abort;
    logic       w_last;
    mdop_t      w_op;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    assign w_rtype = (aluop == ALUOP_RTYPE);
    assign w_is_md = (funct == F_MULTU) || (funct == F_DIVU);
    assign w_is_mf = (funct == F_MFHI) || (funct == F_MFLO);
    assign w_op    = (funct == F_DIVU) ? OP_DIVU : OP_MULTU;

    // R-type funct decode; unknown codes fall back to AND and are flagged
    always_comb begin
        w_rt_ctrl  = ALU_AND;
        w_rt_known = 1'b1;
        case (funct)
            F_ADD:   w_rt_ctrl = ALU_ADD;
            F_SUB:   w_rt_ctrl = ALU_SUB;
            F_AND:   w_rt_ctrl = ALU_AND;
            F_OR:    w_rt_ctrl = ALU_OR;
            F_SLT:   w_rt_ctrl = ALU_SLT;
            F_MULTU, F_DIVU, F_MFHI, F_MFLO: w_rt_ctrl = ALU_ADD;
            default: w_rt_known = 1'b0;
        endcase
    end

    // Main ALU control selection by operation class
    always_comb begin
        alucontrol = w_rt_ctrl;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_OR:  alucontrol = ALU_OR;
            default:   alucontrol = w_rt_ctrl;
        endcase
    end

    assign illegal = valid & w_rtype & ~w_rt_known;
    assign w_start = valid & w_rtype & w_is_md & (r_state == ST_IDLE) & ~flush;
    assign w_step  = (r_state == ST_RUN) & ~flush;
    assign w_abort = flush & (r_state != ST_IDLE);
    assign busy    = (r_state != ST_IDLE);
    // A flush landing in the DONE cycle suppresses both the pulse and the HI/LO write
    assign done    = (r_state == ST_DONE) & ~flush;
    assign stall   = valid & w_rtype & (w_is_md | w_is_mf) & (r_state != ST_IDLE);

    // HI/LO read port for MFHI/MFLO
    always_comb begin
        hilo_rd = '0;
        if (valid && w_rtype && funct == F_MFHI)
            hilo_rd = r_hi;
        else if (valid && w_rtype && funct == F_MFLO)
            hilo_rd = r_lo;
    end

    muldiv_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk     (clk),
        .reset_n (reset_n),
        .i_start (w_start),
        .i_op    (w_op),
        .i_step  (w_step),
        .i_abort (w_abort),
        .i_srca  (srca),
        .i_srcb  (srcb),
        .o_last  (w_last),
        .o_hi    (w_res_hi),
        .o_lo    (w_res_lo)
    );

    // Sequencer: IDLE -> RUN (WIDTH steps) -> DONE (1 cycle) -> IDLE; flush aborts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_start) r_state <= ST_RUN;
                ST_RUN: begin
                    if (flush)       r_state <= ST_IDLE;
                    else if (w_last) r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Architectural HI/LO, committed at the end of an unflushed DONE cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (done) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end
    end

endmodule
